// File: rtl/hex_disp_pkg.sv
// Shared types, segment encodings and helpers for the hex/decimal display controller.
package hex_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic seg_t seg_of(input logic [3:0] nib);
    seg_t code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Value-transfer handshake between a data source and the display controller.
interface hex_display_ctrl_if #(
  parameter int DIGITS = 6
);

  logic [4*DIGITS-1:0] in_value;
  logic                in_valid;
  logic                in_ready;
  logic                mode_dec;

  modport master (
    output in_value,
    output in_valid,
    output mode_dec,
    input  in_ready
  );

  modport slave (
    input  in_value,
    input  in_valid,
    input  mode_dec,
    output in_ready
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// o_done is high during the final shift, so o_bcd is complete on the following cycle.
module bin2bcd_seq #(
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [4*DIGITS-1:0] i_bin,
  output logic                o_busy,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_bin;
  logic [W-1:0]  r_bcd;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [W-1:0]  w_adj;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == CW'(W - 1));
  assign o_busy = r_busy;
  assign o_bcd  = r_bcd;

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      {r_bcd, r_bin} <= {w_adj[W-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + CW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: accepts a binary value, shows it in hex or
// decimal with leading-zero suppression, per-digit blanking, blinking and overflow dashes.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  hex_display_ctrl_if.slave    bus,
  input  logic                 lz_en,
  input  logic                 blink_en,
  input  logic [DIGITS-1:0]    blank_mask,
  output logic [7*DIGITS-1:0]  seg,
  output logic                 ovf
);

  localparam int              W       = 4 * DIGITS;
  localparam longint unsigned MAX_DEC = pow10(DIGITS) - 64'd1;
  localparam int              BCW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t r_state;
  state_t w_next;

  logic          w_ready;
  logic          w_accept;
  logic          w_conv_start;
  logic          w_commit;
  logic          w_conv_busy;
  logic          w_conv_done;
  logic [W-1:0]  w_bcd;

  logic [W-1:0]  r_pend;
  logic          r_mode;
  logic          r_ovf_pend;

  logic [W-1:0]  r_disp;
  logic          r_disp_ovf;
  logic          r_disp_vld;

  logic [BCW-1:0]      r_blink_cnt;
  logic                r_phase;
  int                  w_msd;
  logic [7*DIGITS-1:0] w_seg;
  logic [7*DIGITS-1:0] r_seg;

  assign w_accept     = bus.in_valid && w_ready;
  assign bus.in_ready = w_ready;

  bin2bcd_seq #(.DIGITS(DIGITS)) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_conv_start),
    .i_bin   (bus.in_value),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = bus.mode_dec ? ST_CONV : ST_LOAD;
      // Falling out on an idle converter keeps the FSM from ever stalling in CONV.
      ST_CONV: if (w_conv_done || !w_conv_busy) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready      = 1'b0;
    w_conv_start = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready      = 1'b1;
        w_conv_start = bus.in_valid && bus.mode_dec;
      end
      ST_LOAD: w_commit = 1'b1;
      default: ;
    endcase
  end

  // Overflow is decided at accept; the conversion still runs so decimal latency is fixed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend     <= '0;
      r_mode     <= 1'b0;
      r_ovf_pend <= 1'b0;
    end else if (w_accept) begin
      r_pend     <= bus.in_value;
      r_mode     <= bus.mode_dec;
      r_ovf_pend <= bus.mode_dec && (64'(bus.in_value) > MAX_DEC);
    end
  end

  // r_disp_vld keeps the display dark after reset until a value has actually been committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp     <= '0;
      r_disp_ovf <= 1'b0;
      r_disp_vld <= 1'b0;
    end else if (w_commit) begin
      r_disp     <= r_mode ? w_bcd : r_pend;
      r_disp_ovf <= r_ovf_pend;
      r_disp_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BCW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BCW'(1);
    end
  end

  always_comb begin
    w_msd = 0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_disp[4*i +: 4] != 4'd0) begin
        w_msd = i;
      end
    end
  end

  always_comb begin
    w_seg = {DIGITS{SEG_BLANK}};
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_disp_vld || (blink_en && r_phase) || blank_mask[i]) begin
        w_seg[7*i +: 7] = SEG_BLANK;
      end else if (r_disp_ovf) begin
        w_seg[7*i +: 7] = SEG_DASH;
      end else if (lz_en && (i > w_msd)) begin
        w_seg[7*i +: 7] = SEG_BLANK;
      end else begin
        w_seg[7*i +: 7] = seg_of(r_disp[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= {DIGITS{SEG_BLANK}};
    end else begin
      r_seg <= w_seg;
    end
  end

  assign seg = r_seg;
  assign ovf = r_disp_ovf;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: driver queues expected displays, a monitor
// compares them when the controller returns to ready, plus directed reset/mask/blink checks.
module tb_hex_display_ctrl;

  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  localparam logic [6:0] TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [41:0] seg;
    logic        ovf;
    int          low;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        lz_en;
  logic        blink_en;
  logic [5:0]  blank_mask;
  logic [41:0] seg;
  logic        ovf;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  hex_display_ctrl_if #(.DIGITS(DIGITS)) bus ();

  hex_display_ctrl #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .lz_en      (lz_en),
    .blink_en   (blink_en),
    .blank_mask (blank_mask),
    .seg        (seg),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: digits by plain arithmetic, then the display rules in priority order.
  function automatic logic [41:0] model_seg(input logic [23:0] v, input bit dec,
                                            input bit lz, input logic [5:0] mask);
    int unsigned val;
    int unsigned hv;
    int unsigned d[6];
    int          msd;
    bit          ov;
    logic [41:0] r;
    val = v;
    hv  = v;
    ov  = dec && (val > 999999);
    for (int i = 0; i < 6; i++) begin
      if (dec) begin
        d[i] = val % 10;
        val  = val / 10;
      end else begin
        d[i] = hv % 16;
        hv   = hv / 16;
      end
    end
    msd = 0;
    for (int i = 0; i < 6; i++) if (d[i] != 0) msd = i;
    for (int i = 0; i < 6; i++) begin
      if (mask[i])             r[7*i +: 7] = 7'h7F;
      else if (ov)             r[7*i +: 7] = 7'h3F;
      else if (lz && (i > msd)) r[7*i +: 7] = 7'h7F;
      else                     r[7*i +: 7] = TBL[d[i]];
    end
    return r;
  endfunction

  task automatic send(input logic [23:0] v, input bit dec);
    exp_t e;
    int   t;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      fail_now("ready_wait");
      return;
    end
    bus.in_value = v;
    bus.mode_dec = dec;
    bus.in_valid = 1'b1;
    e.seg = model_seg(v, dec, lz_en, blank_mask);
    e.ovf = dec && (v > 24'd999999);
    e.low = dec ? 25 : 1;
    sb_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_value = 24'($urandom);
    bus.mode_dec = 1'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      fail_now("completion_wait");
      sb_q.delete();
    end
  endtask

  // Monitor: a low->high in_ready marks completion; seg is due one edge later.
  initial begin : monitor
    bit   prev_ready;
    int   low_cnt;
    exp_t e;
    prev_ready = 1'b1;
    low_cnt    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ready = 1'b1;
        low_cnt    = 0;
      end else if (!bus.in_ready) begin
        low_cnt++;
        prev_ready = 1'b0;
      end else if (!prev_ready) begin
        prev_ready = 1'b1;
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_completion: got seg %0h with no pending value", seg);
        end else begin
          e = sb_q.pop_front();
          check("busy_cycles", 64'(low_cnt), 64'(e.low));
          check("seg", 64'(seg), 64'(e.seg));
          check("ovf", 64'(ovf), 64'(e.ovf));
        end
        low_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [41:0] samp[20];
    logic [41:0] val_pat;
    logic [23:0] v;
    bit          dec;
    bit          blank_k;
    int          k;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.mode_dec = 1'b0;
    lz_en        = 1'b0;
    blink_en     = 1'b0;
    blank_mask   = '0;

    repeat (3) @(negedge clk);
    check("rst_seg", 64'(seg), 64'(ALL_BLANK));
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_seg", 64'(seg), 64'(ALL_BLANK));
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);

    // Hex with and without leading-zero suppression, then a live blank mask.
    send(24'h00ABCD, 1'b0);
    wait_done();
    lz_en = 1'b1;
    send(24'h00ABCD, 1'b0);
    wait_done();
    blank_mask = 6'b000001;
    @(negedge clk);
    check("mask_digit0", 64'(seg), 64'(model_seg(24'h00ABCD, 1'b0, 1'b1, 6'b000001)));
    blank_mask = '0;
    lz_en      = 1'b0;

    // Decimal conversion; a valid pulse mid-conversion must be ignored.
    send(24'd123456, 1'b1);
    repeat (5) @(negedge clk);
    check("conv_not_ready", 64'(bus.in_ready), 64'd0);
    bus.in_value = 24'h00BEEF;
    bus.mode_dec = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done();

    // Decimal boundaries, then overflow, then an asynchronous mid-stream reset.
    send(24'd999999, 1'b1);
    wait_done();
    send(24'd1000000, 1'b1);
    wait_done();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_seg", 64'(seg), 64'(ALL_BLANK));
    check("midrst_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_release_seg", 64'(seg), 64'(ALL_BLANK));
    lz_en = 1'b1;
    send(24'd0, 1'b0);
    wait_done();
    lz_en = 1'b0;

    // Blink: once the phase flips, expect exactly 4 blank and 4 value cycles.
    send(24'h012345, 1'b0);
    wait_done();
    val_pat  = model_seg(24'h012345, 1'b0, 1'b0, 6'b0);
    blink_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      samp[j] = seg;
    end
    blink_en = 1'b0;
    k = 0;
    for (int j = 11; j >= 1; j--) begin
      if ((samp[j] == ALL_BLANK) != (samp[j-1] == ALL_BLANK)) k = j;
    end
    if (k == 0) begin
      fail_now("blink_toggle");
    end else begin
      blank_k = (samp[k] == ALL_BLANK);
      for (int j = 0; j < 8; j++) begin
        check("blink", 64'(samp[k+j]),
              64'((((j < 4) ? blank_k : !blank_k)) ? ALL_BLANK : val_pat));
      end
    end

    // Reset during a conversion: nothing from it may ever appear.
    send(24'd654321, 1'b1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("abort_seg", 64'(seg), 64'(ALL_BLANK));
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_still_blank", 64'(seg), 64'(ALL_BLANK));
    check("abort_ready", 64'(bus.in_ready), 64'd1);
    send(24'd654321, 1'b1);
    wait_done();

    // Randomised traffic mixing modes, masks and values around the decimal limit.
    for (int n = 0; n < 24; n++) begin
      dec        = 1'($urandom_range(0, 1));
      lz_en      = 1'($urandom_range(0, 1));
      blank_mask = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      case ($urandom_range(0, 3))
        0:       v = 24'($urandom);
        1:       v = 24'($urandom_range(0, 999999));
        2:       v = 24'($urandom_range(0, 255));
        default: v = 24'($urandom_range(999990, 1000010));
      endcase
      send(v, dec);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Multi-digit seven-segment display controller for the board HEX outputs, generalised to DIGITS digits.
- Accepts a binary value through a valid/ready handshake and shows it as hexadecimal or as decimal.
- Decimal mode uses an iterative binary-to-BCD converter.
- Adds leading-zero suppression, a per-digit blank mask, blinking and overflow indication.
- Sits between software-visible registers or a counter datapath and the active-low segment pins.

Parameters:
- DIGITS, 6, number of digits driven; value width is 4*DIGITS bits.
- BLINK_DIV, 25_000_000, clk cycles per blink half-period (must be ≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_value  input  4*DIGITS  binary value to display.
- in_valid  input  1  in_value valid.
- in_ready  output  1  block can accept a value this cycle.
- mode_dec  input  1  0 = hex, 1 = decimal; sampled at accept.
- lz_en  input  1  leading-zero suppression enable (live).
- blink_en  input  1  blink enable (live).
- blank_mask  input  DIGITS  bit i = 1 forces digit i blank (live).
- seg  output  7*DIGITS  digit i at bits [7i+6:7i], active low, order {g,f,e,d,c,b,a}.
- ovf  output  1  last accepted decimal value exceeded 10^DIGITS-1.

Behaviour:
- Segment code table (active low):
  - 0-9: 40,79,24,30,19,12,02,78,00,10.
  - A-F: 08,03,46,21,06,0E.
  - Blank: 7F. Dash: 3F.
- Reset (asynchronous, any time):
  - seg = all 7F, in_ready = 1, ovf = 0.
  - Stored digits = 0, FSM = IDLE, blink counter = 0, blink phase = 0.
  - Reset during CONV aborts the conversion; nothing from it is ever displayed.
- Handshake:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = 1 only in IDLE.
  - in_valid while in_ready = 0 is ignored; the source must hold the value.
- FSM states: IDLE, CONV, LOAD.
  - IDLE, accept with mode_dec = 0:
    - Digits latched directly from the nibbles of in_value.
    - ovf <= 0.
    - Go to LOAD.
  - IDLE, accept with mode_dec = 1:
    - Compare in_value > 10^DIGITS-1 (localparam).
    - If greater: set the overflow flag and go to CONV anyway, so latency is uniform.
    - Otherwise go to CONV with the shift register loaded.
  - CONV:
    - Shift-add-3 (double dabble), one input bit per cycle, exactly 4*DIGITS cycles.
    - Then go to LOAD.
  - LOAD:
    - Commit converted digits (or all-dash if overflow) and ovf to the display register.
    - Go to IDLE.
- Latency:
  - Hex: seg reflects the new value 2 edges after the accept edge.
  - Decimal: seg reflects it 4*DIGITS+2 edges after the accept edge.
  - in_ready returns high on the edge that leaves LOAD.
- Output stage (registered, 1-cycle latency from live inputs), per digit i, in priority order:
  1. Blank if blink_en && phase.
  2. Else blank if blank_mask[i].
  3. Else dash if overflow.
  4. Else blank if lz_en and i > index of the most significant nonzero digit. Digit 0 is never suppressed by lz_en; value 0 shows a single "0".
  5. Else the table code for the stored digit.
- Blink counter:
  - Free-running 0..BLINK_DIV-1 from reset.
  - phase toggles when the counter wraps.
  - Runs regardless of blink_en, so enabling blink mid-period keeps the phase.
- Width rules:
  - Counter width $clog2(BLINK_DIV), minimum 1.
  - BCD register is 4*DIGITS bits; no-overflow inputs never carry out.

Decomposition:
- Package hex_disp_pkg:
  - typedef seg_t (logic [6:0]).
  - Constants SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F.
  - Function seg_of(logic [3:0]) implementing the 16-entry table.
  - FSM state enum.
- Sub-module bin2bcd_seq (parameter DIGITS):
  - Ports: start, bin in, busy, done, bcd out.
  - Holds the double-dabble shift register and bit counter.
  - Instantiated once and controlled by the parent FSM.

Test Plan:
All scenarios use DIGITS=6 and BLINK_DIV=4.
1. Assert reset mid-stream -> seg=all 7F, in_ready=1, ovf=0 while reset is high and one cycle after release.
2. Hex accept 0x00ABCD, lz_en=0, blank_mask=0 -> 2 edges later seg digits[5..0]=40,40,08,03,46,21, ovf=0.
3. Same value with lz_en=1, then blank_mask=6'b000001 -> digits[5..0]=7F,7F,08,03,46,21; next cycle digit0 becomes 7F.
4. Decimal accept 123456 (0x01E240):
   - in_ready=0 for 25 cycles.
   - Edge 26 -> digits[5..0]=79,24,30,19,12,02, ovf=0.
   - in_valid pulsed during CONV is ignored.
5. Decimal accept 1_000_000 -> after 26 edges all digits 3F, ovf=1. Then hex accept 0 with lz_en=1 -> digits 7F×5 then 40, ovf=0.
6. blink_en=1 with a displayed value -> seg alternates all-7F for 4 cycles and value for 4 cycles. Assert reset during CONV -> conversion aborted, display blank, next accept behaves normally.
